poly_mod_sq_loop_ctrl: RTL

Sequencer for the VDF squaring loop. It accepts a starting value and an iteration count T. It issues one operand at a time to the modular squarer and feeds each result back in as the next operand. After T squarings it returns the final redundant-form result. It sits between the host/command interface and the squarer, and supervises it with a watchdog and abort/drain handling.

---
 rtl/poly_mod_pkg.sv | 13 +
 rtl/poly_mod_sq_loop_ctrl_if.sv | 32 +++
 rtl/poly_mod_sq_loop_ctrl_sq_watchdog.sv | 23 ++
 rtl/poly_mod_sq_loop_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/poly_mod_pkg.sv
// Shared types for the VDF squaring-loop sequencer: FSM state and operand shapes.
package poly_mod_pkg;
  localparam int PKG_WORD_BITS       = 16;
  localparam int PKG_NUM_WORDS       = 8;
  localparam int PKG_REDUN_WORD_BITS = 1;
  localparam int PKG_I_WORD          = PKG_NUM_WORDS + 1;
  localparam int PKG_COEF_BITS       = PKG_WORD_BITS + PKG_REDUN_WORD_BITS;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_t;

  typedef logic [PKG_COEF_BITS-1:0] coef_t;
  typedef coef_t [PKG_I_WORD-1:0]   operand_t;
endpackage

// File: rtl/poly_mod_sq_loop_ctrl_if.sv
// Host command and squarer handshake bundle for the squaring-loop sequencer.
interface poly_mod_sq_loop_ctrl_if #(
  parameter int I_WORD    = 9,
  parameter int COEF_BITS = 17,
  parameter int T_BITS    = 64
);
  logic                                i_start;
  logic [T_BITS-1:0]                   i_t;
  logic [I_WORD-1:0][COEF_BITS-1:0]    i_dat;
  logic                                i_abort;
  logic                                o_ready;
  logic                                o_sq_val;
  logic [I_WORD-1:0][COEF_BITS-1:0]    o_sq_dat;
  logic                                i_sq_val;
  logic [I_WORD-1:0][COEF_BITS-1:0]    i_sq_dat;
  logic                                o_val;
  logic [I_WORD-1:0][COEF_BITS-1:0]    o_dat;
  logic [T_BITS-1:0]                   o_iter;
  logic                                o_err;

  // sequencer side
  modport slave (
    input  i_start, i_t, i_dat, i_abort, i_sq_val, i_sq_dat,
    output o_ready, o_sq_val, o_sq_dat, o_val, o_dat, o_iter, o_err
  );

  // host + squarer side
  modport master (
    output i_start, i_t, i_dat, i_abort, i_sq_val, i_sq_dat,
    input  o_ready, o_sq_val, o_sq_dat, o_val, o_dat, o_iter, o_err
  );
endinterface

// File: rtl/poly_mod_sq_loop_ctrl_sq_watchdog.sv
// Squarer watchdog: counts cycles since the last issue, pulses when the budget is spent.
module sq_watchdog #(
  parameter int WD_CYCLES = 64
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);
  localparam int CW = $clog2(WD_CYCLES + 1);

  logic [CW-1:0] r_cnt;

  // The issue cycle itself counts as elapsed, so a clear loads 1.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                r_cnt <= '0;
    else if (i_clr)           r_cnt <= CW'(1);
    else if (i_en && !o_expire) r_cnt <= r_cnt + CW'(1);
  end

  assign o_expire = i_en && (r_cnt == CW'(WD_CYCLES - 1));
endmodule

// File: rtl/poly_mod_sq_loop_ctrl.sv
// VDF squaring-loop sequencer: issues one operand at a time, feeds results back T times.
module poly_mod_sq_loop_ctrl
  import poly_mod_pkg::*;
#(
  parameter int WORD_BITS       = 16,
  parameter int NUM_WORDS       = 8,
  parameter int REDUN_WORD_BITS = 1,
  parameter int I_WORD          = NUM_WORDS + 1,
  parameter int COEF_BITS       = WORD_BITS + REDUN_WORD_BITS,
  parameter int T_BITS          = 64,
  parameter int WD_CYCLES       = 64
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  poly_mod_sq_loop_ctrl_if.slave bus
);
  state_t                           r_state;
  logic [T_BITS-1:0]                r_t;
  logic [T_BITS-1:0]                r_iter;
  logic [I_WORD-1:0][COEF_BITS-1:0] r_op;
  logic [I_WORD-1:0][COEF_BITS-1:0] r_dat;
  logic                             r_ready;
  logic                             r_sq_val;
  logic                             r_val;
  logic                             r_err;

  logic [T_BITS-1:0] w_iter_nxt;
  logic              w_wd_clr;
  logic              w_wd_en;
  logic              w_wd_exp;

  assign w_iter_nxt = r_iter + T_BITS'(1);
  assign w_wd_clr   = (r_state == S_ISSUE);
  assign w_wd_en    = (r_state == S_WAIT) || (r_state == S_DRAIN);

  sq_watchdog #(.WD_CYCLES(WD_CYCLES)) u_wd (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (w_wd_clr),
    .i_en     (w_wd_en),
    .o_expire (w_wd_exp)
  );

  // Main FSM; the issue strobe is registered on entry to ISSUE so it is visible in that state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_t      <= '0;
      r_iter   <= '0;
      r_op     <= '0;
      r_dat    <= '0;
      r_ready  <= 1'b1;
      r_sq_val <= 1'b0;
      r_val    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_sq_val <= 1'b0;
      r_val    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_err  <= 1'b0;
            r_iter <= '0;
            if (bus.i_t == '0) begin
              r_dat <= bus.i_dat;
              r_val <= 1'b1;
            end else begin
              r_t      <= bus.i_t;
              r_op     <= bus.i_dat;
              r_sq_val <= 1'b1;
              r_ready  <= 1'b0;
              r_state  <= S_ISSUE;
            end
          end
          // A result with nothing in flight is a squarer fault; it outranks the start clear.
          if (bus.i_sq_val) r_err <= 1'b1;
        end
        S_ISSUE: begin
          if (bus.i_sq_val) r_err <= 1'b1;
          if (bus.i_abort) begin
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.i_abort) begin
            // If the result lands with the abort there is nothing left to drain.
            if (bus.i_sq_val) begin
              r_ready <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_DRAIN;
            end
          end else if (bus.i_sq_val) begin
            r_iter <= w_iter_nxt;
            if (w_iter_nxt == r_t) begin
              r_dat   <= bus.i_sq_dat;
              r_val   <= 1'b1;
              r_ready <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_op     <= bus.i_sq_dat;
              r_sq_val <= 1'b1;
              r_state  <= S_ISSUE;
            end
          end else if (w_wd_exp) begin
            r_err   <= 1'b1;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (bus.i_sq_val) begin
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end else if (w_wd_exp) begin
            r_err   <= 1'b1;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_ready  = r_ready;
  assign bus.o_sq_val = r_sq_val;
  assign bus.o_sq_dat = r_op;
  assign bus.o_val    = r_val;
  assign bus.o_dat    = r_dat;
  assign bus.o_iter   = r_iter;
  assign bus.o_err    = r_err;
endmodule
